// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the async FIFO write- and read-domain controllers.
//   Holds the default geometry and the gray/binary pointer conversion helpers.
//   The helpers operate on a fixed 32-bit vector. Callers zero-extend their
//   pointer into it and truncate the result back. Leading zeros do not disturb
//   either conversion, so one function pair serves every pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Default FIFO geometry: depth = 2**FIFO_ADDR_WIDTH entries
    localparam int FIFO_ADDR_WIDTH = 32'sd3;
    // Pointers carry one extra wrap bit to tell full from empty
    localparam int PTR_WIDTH       = FIFO_ADDR_WIDTH + 32'sd1;
    // Width of the vectors handled by the conversion helpers
    localparam int GRAY_FN_WIDTH   = 32'sd32;

    typedef logic [GRAY_FN_WIDTH-1:0] gray_vec_t;

    // Binary to reflected gray code
    function automatic gray_vec_t bin2gray(input gray_vec_t ptr);
        return ptr ^ (ptr >> 32'd1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it
    function automatic gray_vec_t gray2bin(input gray_vec_t ptr);
        gray_vec_t bin;
        logic      acc;
        acc = 1'b0;
        bin = '0;
        for (int i = GRAY_FN_WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ ptr[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
//   Purely combinational gray-to-binary converter built as an XOR prefix chain
//   running from the MSB down to the LSB.
// Ports
//   i_gray  in   WIDTH  gray-coded value
//   o_bin   out  WIDTH  equivalent binary value
// -----------------------------------------------------------------------------
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int WIDTH = PTR_WIDTH
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    logic w_acc;

    // XOR prefix chain from the MSB down to the LSB
    always_comb begin
        w_acc = 1'b0;
        o_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_acc    = w_acc ^ i_gray[i];
            o_bin[i] = w_acc;
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//   Write-domain controller of the async FIFO. Keeps the binary write pointer,
//   publishes its gray-coded form for the read-domain synchronizer and drives
//   the memory write port. It derives full, almost-full, occupancy and a sticky
//   overflow flag from the read pointer. That pointer arrives already
//   synchronized into this clock domain as gray code.
//
//   The read pointer reaches this block two write clocks late. As a result,
//   full and almost-full release later than they would with an exact view.
//   They never release early, so the late release is always safe.
//
// Ports
//   i_clk       in   1             write-domain clock
//   i_rst_n     in   1             asynchronous active-low reset
//   i_w_inc     in   1             write request from the producer
//   i_wq2_rptr  in   ADDR_WIDTH+1  synchronized gray read pointer
//   i_ovf_clr   in   1             clears the sticky overflow flag
//   o_w_en      out  1             memory write enable (combinational)
//   o_w_addr    out  ADDR_WIDTH    binary memory write address
//   o_w_ptr     out  ADDR_WIDTH+1  gray write pointer for the read domain
//   o_full      out  1             FIFO full
//   o_afull     out  1             occupancy >= AFULL_THRESH
//   o_w_level   out  ADDR_WIDTH+1  occupancy seen from the write side
//   o_ovf       out  1             sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH = 32'sd6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_w_inc,
    input  logic [ADDR_WIDTH:0]   i_wq2_rptr,
    input  logic                  i_ovf_clr,
    output logic                  o_w_en,
    output logic [ADDR_WIDTH-1:0] o_w_addr,
    output logic [ADDR_WIDTH:0]   o_w_ptr,
    output logic                  o_full,
    output logic                  o_afull,
    output logic [ADDR_WIDTH:0]   o_w_level,
    output logic                  o_ovf
);

    localparam int                PTR_W     = ADDR_WIDTH + 32'sd1;
    localparam logic [PTR_W-1:0]  AFULL_LVL = PTR_W'(AFULL_THRESH);

    // Registered state
    logic [PTR_W-1:0]      r_wbin;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic [PTR_W-1:0]      r_w_ptr;
    logic                  r_full;
    logic                  r_afull;
    logic [PTR_W-1:0]      r_w_level;
    logic                  r_ovf;

    // Next-state nets
    logic                  w_wr_acc;
    logic [PTR_W-1:0]      w_wbin_n;
    logic [PTR_W-1:0]      w_wgray_n;
    logic [PTR_W-1:0]      w_rbin;
    logic [PTR_W-1:0]      w_full_cmp;
    logic [PTR_W-1:0]      w_level_n;
    logic                  w_full_n;
    logic                  w_afull_n;
    logic                  w_ovf_n;

    // The read pointer is needed in binary for the occupancy subtraction
    fifo_gray2bin #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .i_gray (i_wq2_rptr),
        .o_bin  (w_rbin)
    );

    // A write is accepted only while not full.
    // This also holds during reset, when r_full is 0.
    assign w_wr_acc = i_w_inc & ~r_full;
    assign o_w_en   = w_wr_acc;

    // Pointer, full, level and almost-full next-state evaluation
    always_comb begin
        w_wbin_n   = r_wbin + {{(PTR_W-1){1'b0}}, w_wr_acc};
        w_wgray_n  = PTR_W'(bin2gray(gray_vec_t'(w_wbin_n)));
        // Full: the write pointer is exactly one lap ahead of the read pointer.
        // In gray code this means the top two bits are inverted and the rest are equal.
        w_full_cmp = {~i_wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], i_wq2_rptr[ADDR_WIDTH-2:0]};
        w_full_n   = (w_wgray_n == w_full_cmp);
        // Modular subtraction gives the occupancy directly, including across a wrap
        w_level_n  = w_wbin_n - w_rbin;
        w_afull_n  = (w_level_n >= AFULL_LVL);
    end

    // Sticky overflow: setting wins over a same-cycle clear
    always_comb begin
        if (i_w_inc && r_full) begin
            w_ovf_n = 1'b1;
        end else if (i_ovf_clr) begin
            w_ovf_n = 1'b0;
        end else begin
            w_ovf_n = r_ovf;
        end
    end

    // Controller state registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wbin    <= '0;
            r_w_addr  <= '0;
            r_w_ptr   <= '0;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_w_level <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_wbin    <= w_wbin_n;
            r_w_addr  <= w_wbin_n[ADDR_WIDTH-1:0];
            r_w_ptr   <= w_wgray_n;
            r_full    <= w_full_n;
            r_afull   <= w_afull_n;
            r_w_level <= w_level_n;
            r_ovf     <= w_ovf_n;
        end
    end

    assign o_w_addr  = r_w_addr;
    assign o_w_ptr   = r_w_ptr;
    assign o_full    = r_full;
    assign o_afull   = r_afull;
    assign o_w_level = r_w_level;
    assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
//   Directed bench for fifo_wr_ctrl with ADDR_WIDTH=3 and AFULL_THRESH=6.
//   Inputs change on the falling clock edge and outputs are sampled there too,
//   half a period away from the rising edge that updates the design.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       rst_n;
    logic       w_inc;
    logic [3:0] wq2_rptr;
    logic       ovf_clr;
    logic       w_en;
    logic [2:0] w_addr;
    logic [3:0] w_ptr;
    logic       full;
    logic       afull;
    logic [3:0] w_level;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    // Gray write pointer after each of the first eight writes from empty
    logic [3:0] fill_gray [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    fifo_wr_ctrl #(
        .ADDR_WIDTH   (3),
        .AFULL_THRESH (6)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_w_inc    (w_inc),
        .i_wq2_rptr (wq2_rptr),
        .i_ovf_clr  (ovf_clr),
        .o_w_en     (w_en),
        .o_w_addr   (w_addr),
        .o_w_ptr    (w_ptr),
        .o_full     (full),
        .o_afull    (afull),
        .o_w_level  (w_level),
        .o_ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_ptr"},   32'(w_ptr),   32'd0);
        check({tag, "_addr"},  32'(w_addr),  32'd0);
        check({tag, "_level"}, 32'(w_level), 32'd0);
        check({tag, "_full"},  32'(full),    32'd0);
        check({tag, "_afull"}, 32'(afull),   32'd0);
        check({tag, "_ovf"},   32'(ovf),     32'd0);
    endtask

    logic [3:0] prev_ptr;
    logic [2:0] prev_addr;
    logic [3:0] hist0, hist1;
    int         wraps;
    int         msb_toggles;

    initial begin
        rst_n    = 1'b0;
        w_inc    = 1'b0;
        ovf_clr  = 1'b0;
        wq2_rptr = 4'h0;
        #2;
        check_zero_state("por");
        check("por_w_en", 32'(w_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Reset in the middle of a burst, with no clock edge required
        w_inc = 1'b1;
        repeat (3) @(negedge clk);
        check("burst3_ptr",   32'(w_ptr),   32'h2);
        check("burst3_addr",  32'(w_addr),  32'd3);
        check("burst3_level", 32'(w_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_state("midrst");
        check("midrst_w_en", 32'(w_en), 32'd1);
        w_inc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 2. Fill from empty with back-to-back writes
        wq2_rptr = 4'h0;
        w_inc    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("fill_ptr",   32'(w_ptr),   32'(fill_gray[k-1]));
            check("fill_level", 32'(w_level), 32'(k));
            check("fill_afull", 32'(afull),   (k >= 6) ? 32'd1 : 32'd0);
            check("fill_full",  32'(full),    (k == 8) ? 32'd1 : 32'd0);
        end

        // 3. Overflow while full, then clear, then set-beats-clear
        #1;
        check("ovf_w_en", 32'(w_en), 32'd0);
        @(negedge clk);
        check("ovf_ptr",   32'(w_ptr),   32'hC);
        check("ovf_addr",  32'(w_addr),  32'd0);
        check("ovf_level", 32'(w_level), 32'd8);
        check("ovf_full",  32'(full),    32'd1);
        check("ovf_set",   32'(ovf),     32'd1);
        w_inc   = 1'b0;
        ovf_clr = 1'b1;
        @(negedge clk);
        check("ovf_clr", 32'(ovf), 32'd0);
        w_inc = 1'b1;
        @(negedge clk);
        check("ovf_set_wins", 32'(ovf),   32'd1);
        check("ovf_hold_ptr", 32'(w_ptr), 32'hC);
        w_inc   = 1'b0;
        ovf_clr = 1'b0;

        // 4. Read-side advances become visible as the level drops
        wq2_rptr = 4'b0001;
        @(negedge clk);
        check("drain1_full",  32'(full),    32'd0);
        check("drain1_level", 32'(w_level), 32'd7);
        check("drain1_afull", 32'(afull),   32'd1);
        wq2_rptr = 4'b0011;
        @(negedge clk);
        check("drain2_level", 32'(w_level), 32'd6);
        check("drain2_afull", 32'(afull),   32'd1);
        wq2_rptr = 4'b0010;
        @(negedge clk);
        check("drain3_level", 32'(w_level), 32'd5);
        check("drain3_afull", 32'(afull),   32'd0);

        // 6. Simultaneous accepted write and read-pointer advance at level 7
        w_inc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("sim_pre_level", 32'(w_level), 32'd7);
        check("sim_pre_ptr",   32'(w_ptr),   32'hF);
        wq2_rptr = 4'b0110;
        #1;
        check("sim_w_en", 32'(w_en), 32'd1);
        @(negedge clk);
        check("sim_level", 32'(w_level), 32'd7);
        check("sim_full",  32'(full),    32'd0);
        check("sim_ptr",   32'(w_ptr),   32'hE);
        check("sim_addr",  32'(w_addr),  32'd3);
        w_inc = 1'b0;

        // 5. Wrap: 20 writes, with the read pointer following the write pointer two cycles late
        #2;
        rst_n    = 1'b0;
        wq2_rptr = 4'h0;
        #1;
        check("wrap_rst_ptr", 32'(w_ptr), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        prev_ptr    = 4'h0;
        prev_addr   = 3'd0;
        hist0       = 4'h0;
        hist1       = 4'h0;
        wraps       = 0;
        msb_toggles = 0;
        w_inc       = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("wrap_onebit", 32'($countones(w_ptr ^ prev_ptr)), 32'd1);
            check("wrap_addr",   32'(w_addr), 32'(k % 8));
            check("wrap_full",   32'(full),   32'd0);
            if (prev_addr == 3'd7 && w_addr == 3'd0) wraps++;
            if (prev_ptr[3] != w_ptr[3]) msb_toggles++;
            prev_ptr  = w_ptr;
            prev_addr = w_addr;
            wq2_rptr  = hist1;
            hist1     = hist0;
            hist0     = w_ptr;
        end
        w_inc = 1'b0;
        check("wrap_count",    32'(wraps),       32'd2);
        check("wrap_msb_togg", 32'(msb_toggles), 32'd2);
        check("wrap_end_ptr",  32'(w_ptr),       32'h6);
        check("wrap_end_addr", 32'(w_addr),      32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
